// File: rtl/dma_priority_arbiter_pkg.sv
// dma_pkg: shared types and helpers for the DMA channel arbiter.
//   arbState_t   : arbiter FSM states
//   chIdx_t      : 2-bit channel index
//   ORDER_RST    : reset / fixed priority order, field[1:0] = highest priority
//   rotate_order : rotating-priority update after channel n has been served
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HLDA = 2'd1,
    GRANT     = 2'd2,
    RELEASE   = 2'd3
  } arbState_t;

  typedef logic [1:0] chIdx_t;

  localparam logic [7:0] ORDER_RST = 8'b11_10_01_00;

  // Served channel n drops to lowest priority; n+1 becomes highest.
  function automatic logic [7:0] rotate_order(chIdx_t n);
    chIdx_t f0, f1, f2;
    f0 = n + 2'd1;
    f1 = n + 2'd2;
    f2 = n + 2'd3;
    return {n, f2, f1, f0};
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// dma_priority_arbiter_if: request/handshake bundle between the register
// block / timing control (master side) and the channel arbiter (slave side).
//   inputs to arbiter : DREQ, maskReg, softReq, priorityType, dreqSenseLow,
//                       dackSenseHigh, disableCtrl, HLDA, transferDone
//   outputs           : HRQ, DACK, grantValid, grantChannel, priorityOrder
interface dma_priority_arbiter_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] DREQ;
  logic [NUM_CH-1:0] maskReg;
  logic [NUM_CH-1:0] softReq;
  logic              priorityType;
  logic              dreqSenseLow;
  logic              dackSenseHigh;
  logic              disableCtrl;
  logic              HLDA;
  logic              transferDone;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  logic              grantValid;
  logic [1:0]        grantChannel;
  logic [7:0]        priorityOrder;

  modport master (
    output DREQ, maskReg, softReq, priorityType, dreqSenseLow, dackSenseHigh,
           disableCtrl, HLDA, transferDone,
    input  HRQ, DACK, grantValid, grantChannel, priorityOrder
  );

  modport slave (
    input  DREQ, maskReg, softReq, priorityType, dreqSenseLow, dackSenseHigh,
           disableCtrl, HLDA, transferDone,
    output HRQ, DACK, grantValid, grantChannel, priorityOrder
  );
endinterface

// File: rtl/dma_priority_arbiter_resolver.sv
// dma_priority_resolver: combinational priority pick.
//   eff    : effective per-channel requests
//   order  : four 2-bit channel fields, field0 = highest priority
//   winner : first channel in order with its request set
//   valid  : any request set
module dma_priority_resolver
  import dma_pkg::*;
(
  input  logic [3:0] eff,
  input  logic [7:0] order,
  output chIdx_t     winner,
  output logic       valid
);
  // Scan lowest priority first so the highest-priority hit overwrites.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (eff[order[2*k +: 2]]) begin
        winner = order[2*k +: 2];
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: 4-channel DMA arbiter. Combines DREQ, mask and
// software requests, runs the HRQ/HLDA handshake and holds a one-hot DACK
// until timing control reports end of service.
//   CLK, RESET_N : clock, async active-low reset
//   bus (slave)  : request inputs, HLDA/transferDone in; HRQ, DACK,
//                  grantValid, grantChannel, priorityOrder out
// Build option: DMA_ARB_DREQ_SYNC_EN adds a 2-flop DREQ synchronizer
// (DREQ-to-HRQ latency becomes 3 cycles; softReq is not synchronized).
module dma_priority_arbiter #(
  parameter int         NUM_CH    = 4,
  parameter logic [7:0] ORDER_RST = dma_pkg::ORDER_RST
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  dma_priority_arbiter_if.slave bus
);
  import dma_pkg::*;

  arbState_t         state;
  logic              hrq_q;
  logic              gvalid_q;
  chIdx_t            gch_q;
  logic [NUM_CH-1:0] ack_q;
  logic [7:0]        order_q;
  logic [NUM_CH-1:0] dreq_q;
  logic [NUM_CH-1:0] eff;
  chIdx_t            win;
  logic              win_vld;

`ifdef DMA_ARB_DREQ_SYNC_EN
  logic [NUM_CH-1:0] dreq_s1;
  // Reset to the inactive level so no phantom request appears after reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dreq_s1 <= {NUM_CH{bus.dreqSenseLow}};
      dreq_q  <= {NUM_CH{bus.dreqSenseLow}};
    end else begin
      dreq_s1 <= bus.DREQ;
      dreq_q  <= dreq_s1;
    end
  end
`else
  assign dreq_q = bus.DREQ;
`endif

  // Mask only gates hardware requests; software requests always count.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_eff
    assign eff[i] = ((dreq_q[i] ^ bus.dreqSenseLow) & ~bus.maskReg[i]) | bus.softReq[i];
  end

  dma_priority_resolver u_resolver (
    .eff    (eff),
    .order  (order_q),
    .winner (win),
    .valid  (win_vld)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      hrq_q    <= 1'b0;
      gvalid_q <= 1'b0;
      gch_q    <= '0;
      ack_q    <= '0;
      order_q  <= ORDER_RST;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.disableCtrl && |eff) begin
            hrq_q <= 1'b1;
            state <= WAIT_HLDA;
          end
        end
        WAIT_HLDA: begin
          if (bus.disableCtrl || !win_vld) begin
            hrq_q <= 1'b0;
            state <= IDLE;
          end else if (bus.HLDA) begin
            gch_q      <= win;
            ack_q      <= '0;
            ack_q[win] <= 1'b1;
            gvalid_q   <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: begin
          // transferDone wins over a simultaneous HLDA drop.
          if (bus.transferDone) begin
            ack_q    <= '0;
            gvalid_q <= 1'b0;
            hrq_q    <= 1'b0;
            state    <= RELEASE;
          end else if (!bus.HLDA) begin
            ack_q    <= '0;
            gvalid_q <= 1'b0;
            hrq_q    <= 1'b0;
            state    <= IDLE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase

      // Fixed mode continuously restores the reset order.
      if (!bus.priorityType)
        order_q <= ORDER_RST;
      else if (state == RELEASE)
        order_q <= rotate_order(gch_q);
    end
  end

  assign bus.HRQ           = hrq_q;
  assign bus.DACK          = bus.dackSenseHigh ? ack_q : ~ack_q;
  assign bus.grantValid    = gvalid_q;
  assign bus.grantChannel  = gch_q;
  assign bus.priorityOrder = order_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
module tb_dma_priority_arbiter;
  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  dma_priority_arbiter_if #(.NUM_CH(4)) bus ();

  dma_priority_arbiter dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting for HLDA, 2 owning bus, 3 release cycle
  int         m_phase;
  bit         m_hrq;
  int         m_owner;   // -1 when no channel owns the bus
  int         m_last;
  int         m_ord[4];  // m_ord[0] = highest-priority channel
  logic [3:0] m_s1, m_s2, m_d, m_e;
  int         m_pick;

  function automatic logic [3:0] model_eff(logic [3:0] d);
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      r[i] = ((d[i] ^ bus.dreqSenseLow) && !bus.maskReg[i]) || bus.softReq[i];
    return r;
  endfunction

  function automatic int model_pick(logic [3:0] e);
    for (int k = 0; k < 4; k++)
      if (e[m_ord[k]]) return m_ord[k];
    return -1;
  endfunction

  function automatic logic [7:0] model_order();
    logic [7:0] r;
    for (int k = 0; k < 4; k++) r[2*k +: 2] = m_ord[k][1:0];
    return r;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_phase = 0; m_hrq = 0; m_owner = -1; m_last = 0;
      for (int k = 0; k < 4; k++) m_ord[k] = k;
      m_s1 = {4{bus.dreqSenseLow}};
      m_s2 = {4{bus.dreqSenseLow}};
    end else begin
`ifdef DMA_ARB_DREQ_SYNC_EN
      m_d  = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.DREQ;
`else
      m_d = bus.DREQ;
`endif
      m_e    = model_eff(m_d);
      m_pick = model_pick(m_e);
      case (m_phase)
        0: if (!bus.disableCtrl && m_e != 0) begin m_hrq = 1; m_phase = 1; end
        1: if (bus.disableCtrl || m_e == 0) begin m_hrq = 0; m_phase = 0; end
           else if (bus.HLDA) begin m_owner = m_pick; m_phase = 2; end
        2: if (bus.transferDone) begin
             m_last = m_owner; m_owner = -1; m_hrq = 0; m_phase = 3;
           end else if (!bus.HLDA) begin
             m_owner = -1; m_hrq = 0; m_phase = 0;
           end
        default: begin
          if (bus.priorityType)
            for (int k = 0; k < 4; k++) m_ord[k] = (m_last + 1 + k) % 4;
          m_phase = 0;
        end
      endcase
      if (!bus.priorityType)
        for (int k = 0; k < 4; k++) m_ord[k] = k;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    logic [3:0] exp_ack, exp_dack;
    exp_ack  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    exp_dack = bus.dackSenseHigh ? exp_ack : ~exp_ack;
    chk("model_hrq",   32'(bus.HRQ),           32'(m_hrq));
    chk("model_dack",  32'(bus.DACK),          32'(exp_dack));
    chk("model_gval",  32'(bus.grantValid),    32'(m_owner >= 0));
    chk("model_order", 32'(bus.priorityOrder), 32'(model_order()));
    if (m_owner >= 0)
      chk("model_gch", 32'(bus.grantChannel), 32'(m_owner));
  end

  // ---------------- directed stimulus ----------------
  task automatic step(int n = 1);
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  task automatic look();
    @(negedge CLK);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!bus.grantValid && n < 20) begin step(); n++; end
    if (n == 20) begin
      checks++; failures++;
      $display("FAIL wait_grant actual=timeout expected=grantValid");
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    bus.DREQ = 4'b1111; bus.maskReg = 4'b0000; bus.softReq = 4'b0000;
    bus.priorityType = 1'b0; bus.dreqSenseLow = 1'b0; bus.dackSenseHigh = 1'b1;
    bus.disableCtrl = 1'b0; bus.HLDA = 1'b1; bus.transferDone = 1'b0;

    // Reset state with requests and HLDA already active
    step(3);
    look();
    chk("rst_dack",  32'(bus.DACK), 32'h0);
    chk("rst_hrq",   32'(bus.HRQ), 32'h0);
    chk("rst_gval",  32'(bus.grantValid), 32'h0);
    chk("rst_order", 32'(bus.priorityOrder), 32'hE4);
    RESET_N = 1'b1;
    step(3);
    look();
    chk("post_rst_gch", 32'(bus.grantChannel), 32'h0);
    bus.DREQ = 4'b0000; bus.HLDA = 1'b0;
    step(3);

    // Fixed mode, HLDA two cycles after HRQ; done together with HLDA drop
    bus.DREQ = 4'b1110;
    step(); look();
    chk("fix_hrq", 32'(bus.HRQ), 32'h1);
    step();
    bus.HLDA = 1'b1;
    step(); look();
    chk("fix_dack", 32'(bus.DACK), 32'h2);
    bus.transferDone = 1'b1; bus.HLDA = 1'b0; bus.DREQ = 4'b0000;
    step();
    bus.transferDone = 1'b0;
    look();
    chk("fix_done_dack", 32'(bus.DACK), 32'h0);
    chk("fix_done_hrq",  32'(bus.HRQ), 32'h0);
    chk("fix_order",     32'(bus.priorityOrder), 32'hE4);
    step(2);

    // Rotating mode, all channels requesting
    bus.priorityType = 1'b1; bus.DREQ = 4'b1111; bus.HLDA = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant();
      look();
      chk("rot_gch", 32'(bus.grantChannel), 32'(i));
      bus.transferDone = 1'b1;
      step();
      bus.transferDone = 1'b0;
      if (i == 3) begin bus.DREQ = 4'b0000; bus.HLDA = 1'b0; end
      step();
      if (i == 0) begin
        look();
        chk("rot_order_ch0", 32'(bus.priorityOrder), 32'h39);
      end
    end
    bus.priorityType = 1'b0;
    step(2);

    // Masked DREQ ignored, soft request wins (rotating mode, start order E4)
    bus.priorityType = 1'b1;
    bus.maskReg = 4'b0001; bus.DREQ = 4'b0001;
    step(3); look();
    chk("mask_hrq", 32'(bus.HRQ), 32'h0);
    bus.softReq = 4'b0100;
    step(); look();
    chk("soft_hrq", 32'(bus.HRQ), 32'h1);
    bus.HLDA = 1'b1;
    step(); look();
    chk("soft_dack", 32'(bus.DACK), 32'h4);

    // No pre-emption by a higher-priority request; then HLDA abort
    bus.maskReg = 4'b0000; bus.DREQ = 4'b0001;
    step(2); look();
    chk("hold_dack", 32'(bus.DACK), 32'h4);
    bus.HLDA = 1'b0; bus.DREQ = 4'b0000; bus.softReq = 4'b0000;
    step(); look();
    chk("abort_dack",  32'(bus.DACK), 32'h0);
    chk("abort_hrq",   32'(bus.HRQ), 32'h0);
    chk("abort_order", 32'(bus.priorityOrder), 32'hE4);
    bus.priorityType = 1'b0;
    step(2);

    // Short DREQ pulse without HLDA
    bus.DREQ = 4'b1000;
    step(); look();
    chk("pulse_hrq_up", 32'(bus.HRQ), 32'h1);
    step();
    bus.DREQ = 4'b0000;
    step(); look();
    chk("pulse_hrq_dn", 32'(bus.HRQ), 32'h0);
    chk("pulse_dack",   32'(bus.DACK), 32'h0);
    step(2);

    // Inverted polarities
    bus.dackSenseHigh = 1'b0; bus.dreqSenseLow = 1'b1; bus.DREQ = 4'b1111;
    step(); look();
    chk("pol_idle_dack", 32'(bus.DACK), 32'hF);
    chk("pol_idle_hrq",  32'(bus.HRQ), 32'h0);
    bus.DREQ = 4'b1101;
    step(); look();
    chk("pol_hrq", 32'(bus.HRQ), 32'h1);
    bus.HLDA = 1'b1;
    step(); look();
    chk("pol_dack", 32'(bus.DACK), 32'hD);
    bus.transferDone = 1'b1; bus.DREQ = 4'b1111; bus.HLDA = 1'b0;
    step();
    bus.transferDone = 1'b0;
    step(2);

    // Controller disable
    bus.dackSenseHigh = 1'b1; bus.dreqSenseLow = 1'b0;
    bus.disableCtrl = 1'b1; bus.DREQ = 4'b0100;
    step(2); look();
    chk("dis_idle_hrq", 32'(bus.HRQ), 32'h0);
    bus.disableCtrl = 1'b0;
    step(); look();
    chk("dis_en_hrq", 32'(bus.HRQ), 32'h1);
    bus.disableCtrl = 1'b1;
    step(); look();
    chk("dis_wait_hrq", 32'(bus.HRQ), 32'h0);
    bus.disableCtrl = 1'b0;
    step();
    bus.HLDA = 1'b1;
    step();
    bus.disableCtrl = 1'b1;
    step(2); look();
    chk("dis_grant_dack", 32'(bus.DACK), 32'h4);
    bus.transferDone = 1'b1;
    step();
    bus.transferDone = 1'b0; bus.DREQ = 4'b0000; bus.HLDA = 1'b0; bus.disableCtrl = 1'b0;
    step(2);

    // transferDone while idle has no effect
    bus.transferDone = 1'b1;
    step(2);
    bus.transferDone = 1'b0;
    step(2); look();
    chk("idle_done_hrq", 32'(bus.HRQ), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Channel arbiter for the 4-channel DMA controller.
- Resolves DREQ, software requests and mask bits into one winning channel, runs the HRQ/HLDA bus handshake with the CPU, and drives one-hot DACK.
- Holds the grant until the timing-control block signals end of service.
- Sits between the internal register block (mask, request and command bits) and the timing-control FSM, and owns the fixed/rotating priority order.

Parameters:
- NUM_CH, 4, number of channels; the encoding below is fixed for 4.
- ORDER_RST, 8'b11_10_01_00, reset/fixed priority order; field[1:0] is the highest-priority channel.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- DREQ  in  4  raw channel requests
- maskReg  in  4  1 = channel masked (applies to DREQ only)
- softReq  in  4  request-register bits; cannot be masked
- priorityType  in  1  0 = fixed, 1 = rotating
- dreqSenseLow  in  1  1 = DREQ active-low
- dackSenseHigh  in  1  1 = DACK active-high
- disableCtrl  in  1  command-register controller disable
- HLDA  in  1  hold acknowledge from CPU
- transferDone  in  1  one-cycle pulse from timing control: service of the granted channel has ended
- HRQ  out  1  hold request to CPU
- DACK  out  4  one-hot acknowledge, polarity per dackSenseHigh
- grantValid  out  1  a channel currently owns the bus
- grantChannel  out  2  index of the granted channel
- priorityOrder  out  8  current order register

Behaviour:
- Reset state (asynchronous):
  - state=IDLE, HRQ=0, grantValid=0, grantChannel=0.
  - Internal ack=0; DACK = inactive level (4'b0000 if dackSenseHigh=1, else 4'b1111).
  - priorityOrder=ORDER_RST.
- Effective request: eff[i] = ((DREQ[i]^dreqSenseLow) & ~maskReg[i]) | softReq[i].
- Resolver (combinational): scans fields 0..3 of priorityOrder and picks the first channel with eff set.
- DACK output: DACK = dackSenseHigh ? ack : ~ack, where ack is the registered one-hot.
- FSM states: IDLE, WAIT_HLDA, GRANT, RELEASE.
  - IDLE: if !disableCtrl && |eff, set HRQ=1 at the next edge and go to WAIT_HLDA. Latency is 1 cycle from eff to HRQ.
  - WAIT_HLDA: HRQ held at 1.
    - If |eff falls to 0 before HLDA, HRQ=0 and go to IDLE.
    - If HLDA=1, latch the resolver winner into grantChannel, set ack one-hot, grantValid=1, go to GRANT. DACK is active 1 cycle after HLDA is sampled high.
  - GRANT: winner locked. Higher-priority requests, mask changes and eff deassertion do not pre-empt it.
    - transferDone=1: go to RELEASE.
    - HLDA=0 without transferDone: abort. ack=0, grantValid=0, HRQ=0, no rotation, go to IDLE.
    - transferDone and HLDA drop in the same cycle: treat as normal completion (RELEASE).
  - RELEASE (1 cycle): ack=0, grantValid=0, HRQ=0.
    - If priorityType=1, rotate so the served channel n becomes lowest: order = {n, n+3, n+2, n+1} mod 4, i.e. field0=n+1.
    - Then go to IDLE. HRQ is therefore low for at least 1 cycle between grants.
- Fixed mode: while priorityType=0, priorityOrder is reloaded to ORDER_RST every cycle, so switching mode mid-grant restores the fixed order immediately. Switching 0→1 keeps ORDER_RST as the starting order.
- disableCtrl=1:
  - In IDLE: no HRQ.
  - In WAIT_HLDA: HRQ dropped and go to IDLE next cycle.
  - In GRANT: the current service completes normally.
- transferDone outside GRANT: ignored.

Optional Feature:
- Macro: DMA_ARB_DREQ_SYNC_EN.
- Defined: DREQ passes through a 2-flop synchronizer (reset to the inactive level per dreqSenseLow) before the eff logic. DREQ-to-HRQ latency becomes 3 cycles. softReq is not synchronized.
- Undefined: DREQ is used directly; latency is 1 cycle.

Decomposition:
- Shared package dma_pkg:
  - arbState_t enum (IDLE, WAIT_HLDA, GRANT, RELEASE)
  - ORDER_RST constant
  - chIdx_t (2-bit) typedef
  - rotate-order function
- One sub-module dma_priority_resolver: combinational; inputs eff[3:0] and order[7:0], outputs winner index and valid.
- FSM, ack and order registers remain in the top module.

Test Plan:
- Reset with DREQ=4'b1111 held, HLDA=1: after release, DACK=4'b0000 (dackSenseHigh=1), HRQ=0, priorityOrder=8'hE4.
- Fixed mode, DREQ=4'b1110, HLDA raised 2 cycles after HRQ: DACK=4'b0010 one cycle after HLDA; transferDone → DACK=0, HRQ=0; order stays 8'hE4.
- Rotating mode, DREQ=4'b1111, serve four transfers: grants ch0, ch1, ch2, ch3 in order. Order after ch0 = 8'b00_11_10_01.
- Mask and soft request: maskReg=4'b0001, DREQ=4'b0001, softReq=4'b0000 → HRQ stays 0. Then softReq=4'b0100 → DACK=4'b0100.
- During GRANT of ch2, DREQ0 asserted → DACK stays 4'b0100. Then HLDA drops → DACK=0, HRQ=0, order unchanged.
- DREQ pulse 4'b1000 for 2 cycles with HLDA held 0 → HRQ rises at t+1 and falls one cycle after DREQ removal; no DACK ever asserted.
